ll_comp_unit: RTL and testbench

Streaming line-length feature extractor for the signal-feature pipeline. For each accepted signed sample, it computes the absolute first difference |x[n] − x[n−1]|. It keeps a sliding-window sum of the last `window_len` differences and outputs either the window mean or the saturated window sum, with a one-cycle valid pulse per update. It sits between the sample source (ADC/filter stage) and the downstream feature classifier.

---
 rtl/ll_pkg.sv | 21 ++
 rtl/ll_window_buf.sv | 33 +++
 rtl/ll_comp_unit.sv | 86 ++++++++
 tb/tb_ll_comp_unit.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ll_pkg.sv
// rtl/ll_pkg.sv - shared constants and sizing helpers for the line-length feature extractor
package ll_pkg;

  localparam int default_input_width = 32;
  localparam int default_window_len  = 16;

  function automatic int clog2_int(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Sign-extended difference width plus room for window_len maximal entries.
  function automatic int acc_width(input int input_width, input int window_len);
    return input_width + 1 + clog2_int(window_len);
  endfunction

endpackage

// File: rtl/ll_window_buf.sv
// rtl/ll_window_buf.sv - circular buffer of absolute differences, write-and-read-oldest per cycle
module ll_window_buf
  import ll_pkg::*;
#(
  parameter int width = default_input_width + 1,
  parameter int depth = default_window_len
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [width-1:0] wr_data,
  output logic [width-1:0] oldest
);

  localparam int ptr_width = clog2_int(depth);

  logic [width-1:0]     mem [depth];
  logic [ptr_width-1:0] wr_ptr;

  // The slot about to be overwritten holds the entry leaving the window.
  assign oldest = mem[wr_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/ll_comp_unit.sv
// rtl/ll_comp_unit.sv - sliding-window line-length extractor; LL_MEAN_OUT_EN selects mean output over saturated sum
module ll_comp_unit
  import ll_pkg::*;
#(
  parameter int input_width = default_input_width,
  parameter int window_len  = default_window_len
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [input_width-1:0] din,
  input  logic                          en,
  output logic signed [input_width:0]   dout,
  output logic                          data_valid
);

  localparam int lw = clog2_int(window_len);
  localparam int aw = acc_width(input_width, window_len);
  localparam int dw = input_width + 1;
  localparam logic [lw:0] fill_full = (lw + 1)'(window_len);

  logic signed [input_width-1:0] prev;
  logic                          primed;
  logic [aw-1:0]                 acc;
  logic [lw:0]                   fill;

  logic signed [dw-1:0] diff;
  logic [dw-1:0]        abs_diff;
  logic [dw-1:0]        oldest;
  logic [aw-1:0]        acc_next;
  logic [lw:0]          fill_next;
  logic [dw-1:0]        result;
  logic                 step;

  assign step = en && primed;

  ll_window_buf #(
    .width(dw),
    .depth(window_len)
  ) u_window_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (step),
    .wr_data(abs_diff),
    .oldest (oldest)
  );

  always_comb begin
    diff      = dw'(din) - dw'(prev);
    abs_diff  = diff[dw-1] ? -diff : diff;
    // acc always covers oldest, so the subtraction never wraps.
    acc_next  = acc + aw'(abs_diff) - aw'(oldest);
    fill_next = (fill == fill_full) ? fill : fill + 1'b1;
`ifdef LL_MEAN_OUT_EN
    result    = acc_next[aw-1:lw];
`else
    if (|acc_next[aw-1:input_width]) result = {1'b0, {input_width{1'b1}}};
    else                             result = {1'b0, acc_next[input_width-1:0]};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      primed     <= 1'b0;
      acc        <= '0;
      fill       <= '0;
      dout       <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (en) begin
        prev   <= din;
        primed <= 1'b1;
        if (primed) begin
          acc  <= acc_next;
          fill <= fill_next;
          if (fill_next == fill_full) begin
            dout       <= result;
            data_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ll_comp_unit.sv
// tb/tb_ll_comp_unit.sv - table-driven directed bench for ll_comp_unit at input_width=32, window_len=4
module tb_ll_comp_unit;

  typedef struct {
    logic        rst;
    logic        en;
    logic [31:0] din;
    logic        exp_valid;
    logic [32:0] exp_dout;
  } vec_t;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [31:0] din;
  logic signed [32:0] dout;
  logic               data_valid;

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  ll_comp_unit #(
    .input_width(32),
    .window_len (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .en        (en),
    .dout      (dout),
    .data_valid(data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output for a given window sum, in whichever output mode is built.
  function automatic logic [32:0] e(input longint unsigned s);
`ifdef LL_MEAN_OUT_EN
    return 33'(s >> 2);
`else
    return (s > 64'hFFFF_FFFF) ? 33'h0_FFFF_FFFF : 33'(s);
`endif
  endfunction

  task automatic add(input logic r, input logic n, input logic [31:0] d,
                     input logic v, input logic [32:0] o);
    vec_t t;
    t.rst = r; t.en = n; t.din = d; t.exp_valid = v; t.exp_dout = o;
    vecs.push_back(t);
  endtask

  task automatic check_outs(input string name, input int idx,
                            input logic v, input logic [32:0] o);
    checks++;
    if (data_valid !== v) begin
      failures++;
      $display("FAIL %s[%0d] data_valid=%0b expected=%0b", name, idx, data_valid, v);
    end
    checks++;
    if (dout !== o) begin
      failures++;
      $display("FAIL %s[%0d] dout=%0d expected=%0d", name, idx, dout, o);
    end
  endtask

  initial begin
    bit got;
    rst = 1'b1; en = 1'b0; din = '0;

    // Reset with en asserted, then ramp and sliding window.
    add(1, 1, 5, 0, 0);
    add(1, 1, 7, 0, 0);
    add(0, 1, 0, 0, 0);
    add(0, 1, 10, 0, 0);
    add(0, 1, 20, 0, 0);
    add(0, 1, 30, 0, 0);
    add(0, 1, 40, 1, e(40));
    add(0, 1, 40, 1, e(30));
    add(0, 1, 40, 1, e(20));
    add(0, 1, 40, 1, e(10));
    add(0, 1, 40, 1, e(0));
    // Extreme alternation: every difference is 2^32-1.
    add(1, 0, 0, 0, 0);
    add(0, 1, 32'h8000_0000, 0, 0);
    add(0, 1, 32'h7FFF_FFFF, 0, 0);
    add(0, 1, 32'h8000_0000, 0, 0);
    add(0, 1, 32'h7FFF_FFFF, 0, 0);
    add(0, 1, 32'h8000_0000, 1, e(64'd17179869180));
    add(0, 1, 32'h7FFF_FFFF, 1, e(64'd17179869180));
    // Gapped ramp.
    add(1, 0, 0, 0, 0);
    add(0, 0, 99, 0, 0);
    add(0, 1, 0, 0, 0);
    add(0, 0, 77, 0, 0);
    add(0, 1, 10, 0, 0);
    add(0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0);
    add(0, 1, 20, 0, 0);
    add(0, 0, 0, 0, 0);
    add(0, 1, 30, 0, 0);
    add(0, 0, 0, 0, 0);
    add(0, 1, 40, 1, e(40));
    add(0, 0, 123, 0, e(40));
    add(0, 0, 0, 0, e(40));
    add(0, 1, 100, 1, e(90));
    add(0, 1, 200, 1, e(180));
    // Mid-window reset after three differences.
    add(1, 0, 0, 0, 0);
    add(0, 1, 100, 0, 0);
    add(0, 1, 200, 0, 0);
    add(0, 1, 300, 0, 0);
    add(0, 1, 400, 0, 0);
    add(1, 1, 500, 0, 0);
    add(0, 1, 5, 0, 0);
    add(0, 1, 6, 0, 0);
    add(0, 1, 8, 0, 0);
    add(0, 1, 11, 0, 0);
    add(0, 1, 15, 1, e(10));
    add(0, 1, 15, 1, e(9));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; en = vecs[i].en; din = vecs[i].din;
      @(posedge clk);
      #1;
      check_outs("vec", i, vecs[i].exp_valid, vecs[i].exp_dout);
    end

    // Idle run: no pulses, dout held.
    @(negedge clk);
    rst = 1'b0; en = 1'b0; din = 32'sd999;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check_outs("idle", k, 1'b0, e(9));
    end

    // One more sample; the pulse must arrive within a bounded number of cycles.
    @(negedge clk);
    en = 1'b1; din = 32'sd15;
    got = 1'b0;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge clk);
      #1;
      en = 1'b0;
      if (data_valid === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL wait_valid data_valid=0 expected=1 within 4 cycles");
    end else begin
      checks++;
      if (dout !== e(7)) begin
        failures++;
        $display("FAIL wait_dout dout=%0d expected=%0d", dout, e(7));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
